iob_sync_fifo_ctrl: RTL and testbench

Synchronous FIFO controller that drives the write and read ports of an external two-port RAM (`iob_2p_ram`, one-cycle registered read). It owns the write/read pointers, occupancy level and full/empty flags, and turns push/pop requests into RAM port accesses. It is instantiated beside a two-port RAM wherever a same-clock FIFO is needed.

---
 rtl/iob_2p_ram.sv | 25 ++
 rtl/iob_fifo_ptr.sv | 26 ++
 rtl/iob_sync_fifo_ctrl.sv | 84 ++++++++
 tb/tb_iob_sync_fifo_ctrl.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/iob_2p_ram.sv
// Two-port RAM: synchronous write, one-cycle registered read.
module iob_2p_ram #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk,
  input  logic              w_en,
  input  logic [ADDR_W-1:0] w_addr,
  input  logic [DATA_W-1:0] w_data,
  input  logic              r_en,
  input  logic [ADDR_W-1:0] r_addr,
  output logic [DATA_W-1:0] r_data
);

  logic [DATA_W-1:0] mem_q [2**ADDR_W];
  logic [DATA_W-1:0] r_data_q;

  always_ff @(posedge clk) begin
    if (w_en) mem_q[w_addr] <= w_data;
    if (r_en) r_data_q <= mem_q[r_addr];
  end

  assign r_data = r_data_q;

endmodule

// File: rtl/iob_fifo_ptr.sv
// Wrapping ADDR_W-bit FIFO pointer with enable and synchronous active-low reset.
module iob_fifo_ptr #(
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  output logic [ADDR_W-1:0] ptr
);

  logic [ADDR_W-1:0] ptr_q, ptr_d;

  // Natural overflow of the ADDR_W-bit add gives the wrap from DEPTH-1 to 0.
  always_comb begin
    ptr_d = ptr_q;
    if (en) ptr_d = ptr_q + ADDR_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/iob_sync_fifo_ctrl.sv
// Same-clock FIFO controller driving an external two-port RAM with registered read.
module iob_sync_fifo_ctrl #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              w_en,
  input  logic [DATA_W-1:0] w_data,
  output logic              w_full,
  input  logic              r_en,
  output logic [DATA_W-1:0] r_data,
  output logic              r_valid,
  output logic              r_empty,
  output logic [ADDR_W:0]   level,
  output logic              ext_mem_w_en,
  output logic [ADDR_W-1:0] ext_mem_w_addr,
  output logic [DATA_W-1:0] ext_mem_w_data,
  output logic              ext_mem_r_en,
  output logic [ADDR_W-1:0] ext_mem_r_addr,
  input  logic [DATA_W-1:0] ext_mem_r_data
);

  localparam int unsigned    DEPTH      = 2**ADDR_W;
  localparam logic [ADDR_W:0] FULL_LEVEL = (ADDR_W+1)'(DEPTH);

  logic [ADDR_W:0]   level_q, level_d;
  logic              r_valid_q;
  logic              push, pop;
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;

  // Flags decode the current level, so push-on-full and pop-on-empty drop out here.
  assign w_full  = (level_q == FULL_LEVEL);
  assign r_empty = (level_q == '0);
  assign push    = w_en & ~w_full & rst_n;
  assign pop     = r_en & ~r_empty & rst_n;

  iob_fifo_ptr #(
    .ADDR_W(ADDR_W)
  ) u_wr_ptr (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (push),
    .ptr  (wr_ptr)
  );

  iob_fifo_ptr #(
    .ADDR_W(ADDR_W)
  ) u_rd_ptr (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (pop),
    .ptr  (rd_ptr)
  );

  always_comb begin
    level_d = level_q;
    unique case ({push, pop})
      2'b10:   level_d = level_q + (ADDR_W+1)'(1);
      2'b01:   level_d = level_q - (ADDR_W+1)'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      level_q   <= '0;
      r_valid_q <= 1'b0;
    end else begin
      level_q   <= level_d;
      r_valid_q <= pop;
    end
  end

  assign level          = level_q;
  assign r_valid        = r_valid_q;
  assign r_data         = ext_mem_r_data;
  assign ext_mem_w_en   = push;
  assign ext_mem_w_addr = wr_ptr;
  assign ext_mem_w_data = w_data;
  assign ext_mem_r_en   = pop;
  assign ext_mem_r_addr = rd_ptr;

endmodule

// File: tb/tb_iob_sync_fifo_ctrl.sv
// Self-checking bench: FIFO controller plus two-port RAM against a queue-based model.
module tb_iob_sync_fifo_ctrl;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned ADDR_W = 2;
  localparam int          DEPTH  = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              w_en, r_en;
  logic [DATA_W-1:0] w_data;
  logic              w_full, r_valid, r_empty;
  logic [DATA_W-1:0] r_data;
  logic [ADDR_W:0]   level;
  logic              mem_w_en, mem_r_en;
  logic [ADDR_W-1:0] mem_w_addr, mem_r_addr;
  logic [DATA_W-1:0] mem_w_data, mem_r_data;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  iob_sync_fifo_ctrl #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .w_en          (w_en),
    .w_data        (w_data),
    .w_full        (w_full),
    .r_en          (r_en),
    .r_data        (r_data),
    .r_valid       (r_valid),
    .r_empty       (r_empty),
    .level         (level),
    .ext_mem_w_en  (mem_w_en),
    .ext_mem_w_addr(mem_w_addr),
    .ext_mem_w_data(mem_w_data),
    .ext_mem_r_en  (mem_r_en),
    .ext_mem_r_addr(mem_r_addr),
    .ext_mem_r_data(mem_r_data)
  );

  iob_2p_ram #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_ram (
    .clk   (clk),
    .w_en  (mem_w_en),
    .w_addr(mem_w_addr),
    .w_data(mem_w_data),
    .r_en  (mem_r_en),
    .r_addr(mem_r_addr),
    .r_data(mem_r_data)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a queue of stored words plus counts of accepted pushes/pops.
  logic [DATA_W-1:0] q[$];
  bit                exp_valid;
  logic [DATA_W-1:0] exp_data;
  int                n_push, n_pop;

  always @(posedge clk) begin
    if (!rst_n) begin
      q.delete();
      exp_valid = 1'b0;
      n_push    = 0;
      n_pop     = 0;
    end else begin
      bit do_push, do_pop;
      do_push   = w_en && (q.size() != DEPTH);
      do_pop    = r_en && (q.size() != 0);
      exp_valid = do_pop;
      if (do_pop) begin
        exp_data = q.pop_front();
        n_pop++;
      end
      if (do_push) begin
        q.push_back(w_data);
        n_push++;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      int n;
      bit pw, pr;
      n  = q.size();
      pw = rst_n && w_en && (n != DEPTH);
      pr = rst_n && r_en && (n != 0);
      chk("level", 32'(level), 32'(n));
      chk("w_full", 32'(w_full), 32'(n == DEPTH));
      chk("r_empty", 32'(r_empty), 32'(n == 0));
      chk("r_valid", 32'(r_valid), 32'(exp_valid));
      if (exp_valid) chk("r_data", 32'(r_data), 32'(exp_data));
      chk("ext_mem_w_en", 32'(mem_w_en), 32'(pw));
      chk("ext_mem_r_en", 32'(mem_r_en), 32'(pr));
      if (pw) begin
        chk("ext_mem_w_addr", 32'(mem_w_addr), 32'(n_push % DEPTH));
        chk("ext_mem_w_data", 32'(mem_w_data), 32'(w_data));
      end
      if (pr) chk("ext_mem_r_addr", 32'(mem_r_addr), 32'(n_pop % DEPTH));
    end
  end

  // Apply inputs, then return just after the edge that samples them.
  task automatic drive(input bit rn, input bit we, input logic [DATA_W-1:0] wd, input bit re);
    rst_n  = rn;
    w_en   = we;
    w_data = wd;
    r_en   = re;
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [DATA_W-1:0] wd);
    drive(1'b1, 1'b1, wd, 1'b0);
  endtask

  task automatic pop_expect(input string name, input logic [DATA_W-1:0] wd);
    drive(1'b1, 1'b0, 8'h00, 1'b1);
    chk({name, "_valid"}, 32'(r_valid), 32'd1);
    chk(name, 32'(r_data), 32'(wd));
  endtask

  initial begin
    rst_n  = 1'b0;
    w_en   = 1'b1;
    r_en   = 1'b1;
    w_data = 8'h00;
    @(posedge clk);
    #1;
    chk_en = 1'b1;
    chk("rst_mem_w_en", 32'(mem_w_en), 32'd0);
    chk("rst_mem_r_en", 32'(mem_r_en), 32'd0);
    drive(1'b0, 1'b1, 8'hEE, 1'b1);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_empty", 32'(r_empty), 32'd1);
    chk("rst_full", 32'(w_full), 32'd0);
    chk("rst_valid", 32'(r_valid), 32'd0);

    // Fill, overfill, drain, pop on empty.
    push(8'h11); push(8'h22); push(8'h33); push(8'h44);
    chk("fill_level", 32'(level), 32'd4);
    chk("fill_full", 32'(w_full), 32'd1);
    push(8'h55);
    chk("overfill_level", 32'(level), 32'd4);
    pop_expect("drain0", 8'h11);
    pop_expect("drain1", 8'h22);
    pop_expect("drain2", 8'h33);
    pop_expect("drain3", 8'h44);
    drive(1'b1, 1'b0, 8'h00, 1'b0);
    chk("drain_empty", 32'(r_empty), 32'd1);
    drive(1'b1, 1'b0, 8'h00, 1'b1);
    chk("underflow_valid", 32'(r_valid), 32'd0);

    // Wrap-around: pointers pass 3 -> 0 several times.
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < 3; k++) push(8'hA0 + 8'(3 * r + k));
      for (int k = 0; k < 3; k++) pop_expect("wrap", 8'hA0 + 8'(3 * r + k));
    end

    // Push and pop together while full: push dropped.
    for (int k = 0; k < 4; k++) push(8'hC0 + 8'(k));
    drive(1'b1, 1'b1, 8'h66, 1'b1);
    chk("full_both_data", 32'(r_data), 32'hC0);
    chk("full_both_level", 32'(level), 32'd3);
    pop_expect("full_both_d1", 8'hC1);
    pop_expect("full_both_d2", 8'hC2);
    pop_expect("full_both_d3", 8'hC3);

    // Push and pop together while empty: pop dropped.
    drive(1'b1, 1'b1, 8'h77, 1'b1);
    chk("empty_both_level", 32'(level), 32'd1);
    chk("empty_both_valid", 32'(r_valid), 32'd0);
    pop_expect("empty_both_next", 8'h77);

    // Push and pop together at level 2.
    push(8'hD0); push(8'hD1);
    drive(1'b1, 1'b1, 8'h88, 1'b1);
    chk("mid_both_level", 32'(level), 32'd2);
    chk("mid_both_data", 32'(r_data), 32'hD0);
    pop_expect("mid_both_d1", 8'hD1);
    pop_expect("mid_both_d2", 8'h88);

    // Reset mid-operation with a read in flight.
    push(8'h01); push(8'h02);
    pop_expect("pre_reset", 8'h01);
    drive(1'b0, 1'b0, 8'h00, 1'b0);
    chk("midrst_valid", 32'(r_valid), 32'd0);
    chk("midrst_level", 32'(level), 32'd0);
    push(8'h99);
    pop_expect("post_reset", 8'h99);
    drive(1'b1, 1'b0, 8'h00, 1'b0);
    drive(1'b1, 1'b0, 8'h00, 1'b0);

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
